// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-side definitions: bus widths, PC step, bubble encoding and redirect select.
// Also used by the ID stage and the hazard unit.
package instr_fetch_unit_pkg;

  localparam int unsigned ARM_ADDR_W  = 32;
  localparam int unsigned ARM_INST_W  = 32;
  localparam int unsigned ARM_PC_STEP = 4;

  // A pipeline bubble is the all-zeros word.
  localparam logic [ARM_INST_W-1:0] ARM_NOP_INST = '0;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_HOLD   = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

  // A branch takes priority over a stall. The stall is dropped in that case.
  function automatic pc_sel_e pc_select(input logic branch_taken, input logic freeze);
    pc_sel_e sel;
    if (branch_taken)  sel = PC_BRANCH;
    else if (freeze)   sel = PC_HOLD;
    else               sel = PC_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: hazard/branch controls in, instruction memory port, IF/ID outputs.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ARM_ADDR_W,
  parameter int unsigned INST_W = ARM_INST_W
);

  logic              freeze;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_inst,
    output imem_addr, if_pc, if_inst, if_valid
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_inst,
    input  imem_addr, if_pc, if_inst, if_valid
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register with asynchronous active-high reset to a fixed value.
// It also has a load enable: when load is low, the register holds its value.
module pc_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the zero-latency instruction memory
// and captures the returned word into the IF/ID register (branch flush, stall hold).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ARM_ADDR_W,
  parameter int unsigned       INST_W   = ARM_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = ARM_PC_STEP
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_load;

  always_comb begin
    sel     = pc_select(bus.branch_taken, bus.freeze);
    pc_seq  = pc + STEP;
    pc_d    = pc_seq;
    pc_load = 1'b1;
    unique case (sel)
      // Branch targets are forced onto a word boundary.
      PC_BRANCH: pc_d    = bus.branch_addr & ALIGN_MASK;
      PC_HOLD:   pc_load = 1'b0;
      default:   pc_d    = pc_seq;
    endcase
  end

  pc_reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc)
  );

  assign bus.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_pc    <= '0;
      bus.if_inst  <= INST_W'(ARM_NOP_INST);
      bus.if_valid <= 1'b0;
    end else begin
      unique case (sel)
        PC_BRANCH: begin
          bus.if_pc    <= '0;
          bus.if_inst  <= INST_W'(ARM_NOP_INST);
          bus.if_valid <= 1'b0;
        end
        PC_HOLD: begin
          bus.if_pc    <= bus.if_pc;
          bus.if_inst  <= bus.if_inst;
          bus.if_valid <= bus.if_valid;
        end
        default: begin
          bus.if_pc    <= pc_seq;
          bus.if_inst  <= bus.imem_inst;
          bus.if_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table vectors through a scoreboard queue,
// plus hand sequences for reset, PC wrap and mid-cycle asynchronous reset.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus0 ();
  instr_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus1 ();

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A00001;
      32'h0000_0004: return 32'hE3A01002;
      32'h0000_0008: return 32'hE0802001;
      32'h0000_0040: return 32'hE1A00000;
      default:       return 32'h0;
    endcase
  endfunction

  assign bus0.imem_inst = mem(bus0.imem_addr);
  assign bus1.imem_inst = mem(bus1.imem_addr);

  instr_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  instr_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic        freeze;
    logic        branch;
    logic [31:0] baddr;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_valid;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  function automatic vec_t mk(input logic f, input logic b, input logic [31:0] ba,
                              input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic ev);
    vec_t v;
    v.freeze = f; v.branch = b; v.baddr = ba;
    v.e_addr = ea; v.e_inst = ei; v.e_pc = ep; v.e_valid = ev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_dut0(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                          input logic [31:0] ep, input logic ev);
    chk({tag, ".imem_addr"}, bus0.imem_addr, ea);
    chk({tag, ".if_inst"},   bus0.if_inst,   ei);
    chk({tag, ".if_pc"},     bus0.if_pc,     ep);
    chk({tag, ".if_valid"},  32'(bus0.if_valid), 32'(ev));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // freeze branch baddr       imem_addr      if_inst        if_pc          if_valid
    vecs[0]  = mk(0, 0, 32'h0,  32'h04, 32'hE3A00001, 32'h04, 1);
    vecs[1]  = mk(0, 0, 32'h0,  32'h08, 32'hE3A01002, 32'h08, 1);
    vecs[2]  = mk(0, 1, 32'h40, 32'h40, 32'h0,        32'h0,  0);
    vecs[3]  = mk(0, 0, 32'h0,  32'h44, 32'hE1A00000, 32'h44, 1);
    vecs[4]  = mk(0, 1, 32'h04, 32'h04, 32'h0,        32'h0,  0);
    vecs[5]  = mk(0, 0, 32'h0,  32'h08, 32'hE3A01002, 32'h08, 1);
    vecs[6]  = mk(1, 0, 32'h0,  32'h08, 32'hE3A01002, 32'h08, 1);
    vecs[7]  = mk(1, 0, 32'h0,  32'h08, 32'hE3A01002, 32'h08, 1);
    vecs[8]  = mk(0, 0, 32'h0,  32'h0C, 32'hE0802001, 32'h0C, 1);
    vecs[9]  = mk(0, 0, 32'h0,  32'h10, 32'h0,        32'h10, 1);
    vecs[10] = mk(1, 1, 32'h43, 32'h40, 32'h0,        32'h0,  0);
    vecs[11] = mk(1, 0, 32'h0,  32'h40, 32'h0,        32'h0,  0);
    vecs[12] = mk(0, 0, 32'h0,  32'h44, 32'hE1A00000, 32'h44, 1);

    bus0.freeze = 1'b0; bus0.branch_taken = 1'b0; bus0.branch_addr = '0;
    bus1.freeze = 1'b1; bus1.branch_taken = 1'b0; bus1.branch_addr = '0;

    // Reset state
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_dut0("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.dut1.imem_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table vectors through the scoreboard
    for (int i = 0; i < 13; i++) begin
      bus0.freeze       = vecs[i].freeze;
      bus0.branch_taken = vecs[i].branch;
      bus0.branch_addr  = vecs[i].baddr;
      sb.push_back(vecs[i]);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        tests++; failed++;
        $display("FAIL scoreboard: actual=empty required=entry");
      end else begin
        v = sb.pop_front();
        chk_dut0($sformatf("vec%0d", i), v.e_addr, v.e_inst, v.e_pc, v.e_valid);
      end
    end
    bus0.freeze = 1'b0; bus0.branch_taken = 1'b0; bus0.branch_addr = '0;

    // PC wrap on the second instance: while frozen it still sits at reset.
    chk("wrap.hold.imem_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    chk("wrap.hold.if_valid",  32'(bus1.if_valid), 32'h0);
    bus1.freeze = 1'b0;
    @(posedge clk); #1;
    chk("wrap.e1.imem_addr", bus1.imem_addr, 32'h0);
    chk("wrap.e1.if_pc",     bus1.if_pc,     32'h0);
    chk("wrap.e1.if_valid",  32'(bus1.if_valid), 32'h1);
    @(posedge clk); #1;
    chk("wrap.e2.imem_addr", bus1.imem_addr, 32'h4);
    chk("wrap.e2.if_inst",   bus1.if_inst,   32'hE3A00001);
    chk("wrap.e2.if_pc",     bus1.if_pc,     32'h4);

    // Asynchronous reset in mid-cycle while IF/ID holds a valid word
    chk("midrst.pre.if_valid", 32'(bus0.if_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_dut0("midrst", 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk_dut0("midrst.held", 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_dut0("resume", 32'h4, 32'hE3A00001, 32'h4, 1'b1);
    @(posedge clk); #1;
    chk_dut0("resume2", 32'h8, 32'hE3A01002, 32'h8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
